accum_prbs_checker: RTL and testbench
=====================================

Name: accum_prbs_checker

Overview:
- Receive end of the LFSR-stimulus/accumulator datapath.
- Takes a stream of accumulator outputs (result[n+1] = result[n] + lfsr[n], mod 2^WIDTH), differentiates it to recover the LFSR sequence, and self-synchronises a local LFSR model to that sequence.
- Counts matching and mismatching words, and reports lock status.
- Sits on the accumulator's result bus in checker/self-test builds.

Parameters:
- WIDTH, 16, data and LFSR width.
- TAPS, 16'hB400, feedback mask; next(s) = {s[WIDTH-2:0], ^(s & TAPS)}. Bits 15, 13, 12 and 10 are set.
- LOCK_COUNT, 4, consecutive matches in VERIFY required to enter LOCKED (≥1).
- LOSS_COUNT, 3, consecutive mismatches in LOCKED that drop back to HUNT (≥1).
- CNT_W, 16, width of the match and error counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data is a new accumulator sample this cycle
- in_data  in  WIDTH  accumulator output sample
- diff_valid  out  1  diff_data valid (single-cycle pulse)
- diff_data  out  WIDTH  recovered LFSR word (in_data − previous sample)
- locked  out  1  checker is in LOCKED state
- err_pulse  out  1  mismatch detected while LOCKED (single-cycle)
- err_count  out  CNT_W  mismatches while LOCKED, saturating
- match_count  out  CNT_W  matches while LOCKED, saturating

Behaviour:
- Reset values (async, active-high): diff_valid=0, diff_data=0, locked=0, err_pulse=0, err_count=0, match_count=0. Internal state: prev=0, primed=0, model=0, FSM=HUNT, run counters=0.
- Stage 1, differentiator:
  - On in_valid with primed=0: prev<=in_data, primed<=1; no diff_valid.
  - On in_valid with primed=1: diff_data<=in_data−prev (mod 2^WIDTH), diff_valid<=1, prev<=in_data.
  - Otherwise diff_valid<=0.
  - Latency: in_valid at cycle t → diff_valid at t+1.
  - Gaps in in_valid are allowed; the stream semantics are per-sample, not per-cycle.
- Stage 2, checker FSM: acts only on cycles with diff_valid=1; all stage-2 outputs update at t+2. Let pred = next(model).
  - HUNT:
    - diff_data==0 → stay in HUNT (zero is not a valid seed).
    - diff_data≠0 → model<=diff_data, run<=0, go to VERIFY.
  - VERIFY:
    - diff==pred → model<=pred, run++. If run+1==LOCK_COUNT → LOCKED, locked<=1, run<=0.
    - diff≠pred → model<=diff (reseed), run<=0, stay in VERIFY. If diff==0 → HUNT instead.
    - Counters are not touched in VERIFY.
  - LOCKED: model<=pred every word (free-run; never reseed from received data).
    - Match → match_count++ (saturating), miss run<=0.
    - Mismatch → err_pulse<=1 for one cycle, err_count++ (saturating at 2^CNT_W−1), miss run++.
    - If miss run+1==LOSS_COUNT → HUNT, locked<=0 in the same update.
  - err_pulse is 0 on every cycle not flagged above.
- Counters are not cleared on loss of lock; they clear only on reset.
- Wrap-around: subtraction and accumulation are modulo 2^WIDTH; the carry is discarded.
- Reset mid-stream: all state is cleared immediately. The first sample after reset re-primes; it never produces a diff.
- in_valid held low: FSM and counters hold; locked keeps its value.

Decomposition:
- Package accum_chk_pkg holds:
  - the FSM enum typedef (HUNT, VERIFY, LOCKED);
  - default TAPS / WIDTH constants;
  - a function lfsr_next(state, taps).
- One sub-module, accum_diff: stage 1 (prev/primed registers, subtractor, diff_valid), instantiated once.
- The FSM and counters stay in the top module.

Test Plan:
1. Clean lock:
   - Stimulus: reset, then accumulator stream from seed 16'hACE1, accumulator starting at 0. Samples are 16'h0000, 16'hACE1, 16'h06A4, … with in_valid every cycle.
   - Required: first diff 16'hACE1, second 16'h59C3; locked rises after 1 seed + 4 matches; err_count=0; match_count increments once per subsequent word.
2. Single error:
   - Stimulus: while LOCKED, corrupt one sample by XOR 16'h0001.
   - Required: two consecutive diffs mismatch (the corrupted sample and the one after it). Exactly 2 err_pulses, err_count=2, locked stays 1 (LOSS_COUNT=3), and matching resumes on the next word.
3. Loss of lock:
   - Stimulus: replace the stream with a constant 16'h1234 for 4 samples.
   - Required: diffs are 0; after 3 mismatches locked=0 and the FSM is in HUNT; with further zero diffs it stays in HUNT.
4. Bubbles and wrap:
   - Stimulus: the stream from case 1 with in_valid low on alternate cycles, including samples where the accumulator wraps past 16'hFFFF.
   - Required: diff sequence identical to case 1, lock achieved, no errors.
5. Async reset mid-lock:
   - Stimulus: assert rst asynchronously (between clock edges) while LOCKED, then release.
   - Required: all outputs are 0 immediately. The first post-reset sample produces no diff_valid, and relock takes 1+4 words after priming.
6. Counter saturation:
   - Stimulus: CNT_W=4, continuous mismatches with LOSS_COUNT set high.
   - Required: err_count stops at 4'hF and does not wrap.

Source files
------------

// File: rtl/accum_chk_pkg.sv
// Shared types and helpers for the accumulator PRBS checker.
// Holds the checker FSM encoding and the LFSR step function.
package accum_chk_pkg;

  localparam int DEF_WIDTH = 16;
  localparam logic [DEF_WIDTH-1:0] DEF_TAPS = 16'hB400;
  localparam int LFSR_MAXW = 64;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } chk_state_e;

  // Fibonacci step on a w-bit register held in a wide container.
  function automatic logic [LFSR_MAXW-1:0] lfsr_next(
    input logic [LFSR_MAXW-1:0] s,
    input logic [LFSR_MAXW-1:0] taps,
    input int                   w
  );
    logic [LFSR_MAXW-1:0] r;
    r = {s[LFSR_MAXW-2:0], ^(s & taps)};
    for (int i = 0; i < LFSR_MAXW; i++)
      if (i >= w) r[i] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/accum_diff.sv
// Differentiator stage: recovers the LFSR word as the
// difference between consecutive accumulator samples.
module accum_diff
  import accum_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             diff_valid,
  output logic [WIDTH-1:0] diff_data
);

  logic [WIDTH-1:0] prev;
  logic             primed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      primed     <= 1'b0;
      diff_valid <= 1'b0;
      diff_data  <= '0;
    end else begin
      diff_valid <= 1'b0;
      if (in_valid) begin
        prev   <= in_data;
        primed <= 1'b1;
        if (primed) begin
          diff_data  <= in_data - prev;
          diff_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/accum_prbs_checker.sv
// Receive-side checker for the LFSR/accumulator datapath:
// differentiates, self-syncs a local LFSR and counts hits/misses.
module accum_prbs_checker
  import accum_chk_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEF_TAPS),
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_COUNT = 3,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             diff_valid,
  output logic [WIDTH-1:0] diff_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] match_count
);

  localparam int RUN_MAX =
    (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int RUN_W = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_COUNT - 1);

  chk_state_e       state, state_nxt;
  logic [WIDTH-1:0] model, model_nxt, pred;
  logic [RUN_W-1:0] run, run_nxt;
  logic [RUN_W-1:0] miss, miss_nxt;
  logic             hit, fault;

  accum_diff #(.WIDTH(WIDTH)) u_diff (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .diff_valid (diff_valid),
    .diff_data  (diff_data)
  );

  assign pred = WIDTH'(lfsr_next(
    LFSR_MAXW'(model), LFSR_MAXW'(TAPS), WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      model <= '0;
      run   <= '0;
      miss  <= '0;
    end else begin
      state <= state_nxt;
      model <= model_nxt;
      run   <= run_nxt;
      miss  <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    model_nxt = model;
    run_nxt   = run;
    miss_nxt  = miss;
    hit       = 1'b0;
    fault     = 1'b0;
    if (diff_valid) begin
      unique case (state)
        HUNT: begin
          // zero cannot seed the LFSR: it would lock up
          if (diff_data != '0) begin
            model_nxt = diff_data;
            run_nxt   = '0;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (diff_data == pred) begin
            model_nxt = pred;
            if (run == LOCK_LAST) begin
              run_nxt   = '0;
              miss_nxt  = '0;
              state_nxt = LOCKED;
            end else begin
              run_nxt = run + RUN_W'(1);
            end
          end else if (diff_data == '0) begin
            run_nxt   = '0;
            state_nxt = HUNT;
          end else begin
            model_nxt = diff_data;
            run_nxt   = '0;
          end
        end
        LOCKED: begin
          model_nxt = pred;
          if (diff_data == pred) begin
            hit      = 1'b1;
            miss_nxt = '0;
          end else begin
            fault = 1'b1;
            if (miss == LOSS_LAST) begin
              miss_nxt  = '0;
              run_nxt   = '0;
              state_nxt = HUNT;
            end else begin
              miss_nxt = miss + RUN_W'(1);
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse   <= 1'b0;
      err_count   <= '0;
      match_count <= '0;
    end else begin
      err_pulse <= fault;
      if (fault && (err_count != '1))
        err_count <= err_count + CNT_W'(1);
      if (hit && (match_count != '1))
        match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_accum_prbs_checker.sv
// Scoreboard bench for accum_prbs_checker: expected diffs are
// queued as samples are driven and checked as they emerge.
module tb_accum_prbs_checker;

  logic        clk = 1'b0;
  logic        rst, in_valid;
  logic [15:0] in_data;
  logic        diff_valid, locked, err_pulse;
  logic [15:0] diff_data, err_count, match_count;

  logic        rst_s, in_valid_s;
  logic [15:0] in_data_s;
  logic        diff_valid_s, locked_s, err_pulse_s;
  logic [15:0] diff_data_s;
  logic [3:0]  err_count_s, match_count_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_seen = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        primed;
  logic [15:0] prev, acc, lf;

  accum_prbs_checker dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .diff_valid  (diff_valid),
    .diff_data   (diff_data),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .match_count (match_count)
  );

  accum_prbs_checker #(.CNT_W(4), .LOSS_COUNT(40)) dut_s (
    .clk         (clk),
    .rst         (rst_s),
    .in_valid    (in_valid_s),
    .in_data     (in_data_s),
    .diff_valid  (diff_valid_s),
    .diff_data   (diff_data_s),
    .locked      (locked_s),
    .err_pulse   (err_pulse_s),
    .err_count   (err_count_s),
    .match_count (match_count_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (err_pulse === 1'b1) err_seen++;
    if (diff_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_diff: got %h, required none",
                 diff_data);
      end else begin
        mon_e = sb.pop_front();
        if (diff_data !== mon_e.data || cyc != mon_e.due) begin
          n_fail++;
          $display("FAIL diff: got %h @%0d, required %h @%0d",
                   diff_data, cyc, mon_e.data, mon_e.due);
        end
      end
    end
  end

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic gen_init();
    acc = 16'h0000;
    lf  = 16'hACE1;
  endtask

  task automatic gen_step();
    acc = acc + lf;
    lf  = lfsr_ref(lf);
  endtask

  task automatic send(input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    if (primed) begin
      e.data = d - prev;
      e.due  = cyc + 1;
      sb.push_back(e);
    end
    primed = 1'b1;
    prev   = d;
  endtask

  task automatic send_gen();
    send(acc);
    gen_step();
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    primed = 1'b0;
    prev   = 16'h0;
    sb.delete();
  endtask

  task automatic flush(input string tag);
    idle();
    idle();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d diffs pending, required 0",
               tag, sb.size());
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (diff_valid !== 1'b0 || diff_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_diff: got %b/%h, required 0/0000",
               diff_valid, diff_data);
    end
    n_checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b/%b, required 0/0",
               locked, err_pulse);
    end
    n_checks++;
    if (err_count !== 16'h0 || match_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_counts: got %h/%h, required 0/0",
               err_count, match_count);
    end
  endtask

  task automatic test_clean_lock();
    reset_dut();
    gen_init();
    send_gen();
    send_gen();
    idle();
    n_checks++;
    if (diff_valid !== 1'b1 || diff_data !== 16'hACE1) begin
      n_fail++;
      $display("FAIL first_diff: got %b/%h, required 1/ace1",
               diff_valid, diff_data);
    end
    send_gen();
    idle();
    n_checks++;
    if (diff_data !== 16'h59C3) begin
      n_fail++;
      $display("FAIL second_diff: got %h, required 59c3",
               diff_data);
    end
    send_gen();
    send_gen();
    idle();
    idle();
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL early_lock: got %b, required 0", locked);
    end
    send_gen();
    idle();
    idle();
    n_checks++;
    if (locked !== 1'b1 || match_count !== 16'd0
        || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL lock: got %b m=%0d e=%0d, required 1 m=0 e=0",
               locked, match_count, err_count);
    end
    repeat (5) send_gen();
    idle();
    idle();
    n_checks++;
    if (match_count !== 16'd5 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL match_count: got m=%0d e=%0d, required 5/0",
               match_count, err_count);
    end
    flush("clean");
  endtask

  task automatic test_single_error();
    int e0;
    e0 = err_seen;
    send(acc ^ 16'h0001);
    gen_step();
    repeat (3) send_gen();
    idle();
    idle();
    n_checks++;
    if (err_seen - e0 != 2 || err_count !== 16'd2) begin
      n_fail++;
      $display("FAIL single_err: got pulses=%0d cnt=%0d, required 2/2",
               err_seen - e0, err_count);
    end
    n_checks++;
    if (locked !== 1'b1 || match_count !== 16'd7
        || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL resume: got l=%b m=%0d p=%b, required 1/7/0",
               locked, match_count, err_pulse);
    end
    flush("single");
  endtask

  task automatic test_loss();
    int e0;
    e0 = err_seen;
    repeat (3) send(16'h1234);
    idle();
    idle();
    n_checks++;
    if (locked !== 1'b0 || err_count !== 16'd5) begin
      n_fail++;
      $display("FAIL loss: got l=%b e=%0d, required 0/5",
               locked, err_count);
    end
    repeat (4) send(16'h1234);
    idle();
    idle();
    n_checks++;
    if (locked !== 1'b0 || err_count !== 16'd5
        || err_seen - e0 != 3) begin
      n_fail++;
      $display("FAIL hunt_hold: got l=%b e=%0d p=%0d, required 0/5/3",
               locked, err_count, err_seen - e0);
    end
    flush("loss");
  endtask

  task automatic test_bubbles_wrap();
    reset_dut();
    gen_init();
    repeat (40) begin
      send_gen();
      idle();
    end
    idle();
    n_checks++;
    if (locked !== 1'b1 || err_count !== 16'd0
        || match_count !== 16'd34) begin
      n_fail++;
      $display("FAIL bubbles: got l=%b e=%0d m=%0d, required 1/0/34",
               locked, err_count, match_count);
    end
    flush("bubbles");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (locked !== 1'b0 || diff_valid !== 1'b0
        || diff_data !== 16'h0 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL async_flags: got l=%b v=%b d=%h p=%b, required 0",
               locked, diff_valid, diff_data, err_pulse);
    end
    n_checks++;
    if (err_count !== 16'h0 || match_count !== 16'h0) begin
      n_fail++;
      $display("FAIL async_counts: got %h/%h, required 0/0",
               err_count, match_count);
    end
    @(negedge clk);
    rst    = 1'b0;
    primed = 1'b0;
    sb.delete();
    gen_init();
    send_gen();
    idle();
    n_checks++;
    if (diff_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prime_no_diff: got %b, required 0", diff_valid);
    end
    repeat (4) send_gen();
    idle();
    idle();
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL relock_early: got %b, required 0", locked);
    end
    send_gen();
    idle();
    idle();
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: got %b, required 1", locked);
    end
    flush("areset");
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    gen_init();
    repeat (6) begin
      @(negedge clk);
      in_valid_s = 1'b1;
      in_data_s  = acc;
      gen_step();
    end
    repeat (10) begin
      @(negedge clk);
      in_data_s = 16'h1234;
    end
    @(negedge clk);
    in_valid_s = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_count_s !== 4'hA || locked_s !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_mid: got e=%h l=%b, required a/1",
               err_count_s, locked_s);
    end
    repeat (10) begin
      @(negedge clk);
      in_valid_s = 1'b1;
      in_data_s  = 16'h1234;
    end
    @(negedge clk);
    in_valid_s = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_count_s !== 4'hF || locked_s !== 1'b1
        || match_count_s !== 4'h0) begin
      n_fail++;
      $display("FAIL sat_end: got e=%h l=%b m=%h, required f/1/0",
               err_count_s, locked_s, match_count_s);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 16'h0;
    rst_s      = 1'b1;
    in_valid_s = 1'b0;
    in_data_s  = 16'h0;
    primed     = 1'b0;
    prev       = 16'h0;
    gen_init();
    #3;
    test_reset();
    @(negedge clk);
    rst   = 1'b0;
    rst_s = 1'b0;
    test_clean_lock();
    test_single_error();
    test_loss();
    test_bubbles_wrap();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
